icw_sequencer: RTL and testbench
================================

ICW_SEQUENCER -- requirements
Module: icw_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port CS, input, 1, active-low chip select, synchronous to clk.
REQ-004 SHALL have port WR, input, 1, active-low write strobe, synchronous to clk.
REQ-005 SHALL have port A0, input, 1, register address bit.
REQ-006 SHALL have port data_in, input, 8, write data from the read/write stage internal bus.
REQ-007 SHALL have port icw_to_be_sent, output, 2, next expected ICW: 00 ICW1/none, 01 ICW2, 10 ICW3, 11 ICW4.
REQ-008 SHALL have port init_done, output, 1, high once the initialization sequence is complete.
REQ-009 SHALL have port vector_base, output, 5, ICW2[7:3].
REQ-010 SHALL have port sngl, output, 1, ICW1[1].
REQ-011 SHALL have port ic4, output, 1, ICW1[0].
REQ-012 SHALL have port ltim, output, 1, ICW1[3].
REQ-013 SHALL have port cascade_reg, output, 8, ICW3 contents.
REQ-014 SHALL have port aeoi, output, 1, ICW4[1].
REQ-015 SHALL have port mask_reg, output, 8, OCW1 interrupt mask.
REQ-016 SHALL have port eoi_pulse, output, 1, one-cycle end-of-interrupt command strobe.
REQ-017 SHALL have port eoi_specific, output, 1, OCW2[6] of the last EOI.
REQ-018 SHALL have port eoi_level, output, 3, OCW2[2:0] of the last EOI.
REQ-019 SHALL have port read_isr, output, 1, status-read select: 0 IRR, 1 ISR.
REQ-020 SHALL have port poll_pulse, output, 1, one-cycle OCW3 poll command strobe.

Function
REQ-021 SHALL latch CS, A0 and data_in into holding registers on every edge where WR==0.
REQ-022 SHALL register WR as wr_q.
REQ-023 SHALL define a write event as an edge where WR==1, wr_q==0 and held CS==0; only held A0/data are used, and all register/state updates take effect at that edge.
REQ-024 SHALL treat a write ending with held CS==1 as no event; all other cycles leave state unchanged.
REQ-025 SHALL implement FSM states IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-026 SHALL drive icw_to_be_sent 00/01/10/11/00 in the respective states.
REQ-027 SHALL assert init_done only in READY.
REQ-028 SHALL treat held A0==0 with data[4]==1 as ICW1 in any state, including mid-sequence and READY.
REQ-029 On ICW1 SHALL load ltim/sngl/ic4, clear mask_reg, aeoi, cascade_reg and read_isr, and go to WAIT_ICW2.
REQ-030 In WAIT_ICW2, SHALL accept an A0==1 write: load vector_base=data[7:3]; next state is WAIT_ICW3 if sngl==0, else WAIT_ICW4 if ic4==1, else READY.
REQ-031 In WAIT_ICW3, SHALL accept an A0==1 write: load cascade_reg; next state is WAIT_ICW4 if ic4==1, else READY.
REQ-032 In WAIT_ICW4, SHALL accept an A0==1 write: load aeoi=data[1]; go to READY.
REQ-033 In WAIT states, SHALL ignore A0==0 writes that are not ICW1; in IDLE, SHALL ignore all non-ICW1 writes.
REQ-034 In READY, an A0==1 write SHALL load mask_reg (OCW1).
REQ-035 In READY, an A0==0 write with data[4:3]==00 (OCW2) and data[5]==1 SHALL assert eoi_pulse for exactly the following cycle and load eoi_specific=data[6], eoi_level=data[2:0]; data[5]==0 SHALL be ignored.
REQ-036 In READY, an A0==0 write with data[4:3]==01 (OCW3) SHALL load read_isr=data[0] if data[1]==1, and SHALL assert poll_pulse for one cycle if data[2]==1.
REQ-037 eoi_pulse and poll_pulse SHALL never be high for two consecutive cycles from one write event.
REQ-038 Writes with WR held low for multiple cycles SHALL produce exactly one event, and the last held values SHALL be used.

Reset
REQ-039 Reset SHALL force IDLE, clear wr_q, holding registers and every output to 0 (icw_to_be_sent=00, init_done=0, mask_reg=00), and override any simultaneous write event.
REQ-040 Reset asserted mid-sequence SHALL require a fresh ICW1 after release.

Verification
REQ-041 Reset, then ICW1=0x13, ICW2=0x48 -> vector_base=0x09, icw_to_be_sent 01->11, ICW4=0x03 -> aeoi=1, init_done=1.
REQ-042 ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x01 -> cascade_reg=0x04, aeoi=0, state sequence 01,10,11, then READY.
REQ-043 In READY, OCW1 A0=1 0xF0 -> mask_reg=0xF0; OCW2 0x63 -> single eoi_pulse, eoi_specific=1, eoi_level=3.
REQ-044 OCW3 0x0B -> read_isr=1; OCW3 0x0C -> one poll_pulse and read_isr unchanged; write with CS=1 -> no change.
REQ-045 In READY with mask_reg=0xF0, ICW1=0x12 -> mask_reg=00, init_done=0; after ICW2 -> READY directly; reset asserted during WAIT_ICW2 -> IDLE, all outputs 0.

Source files
------------

// File: rtl/icw_sequencer_if.sv
// Write-port bundle from the read/write stage: active-low CS/WR strobes, A0 and the data bus.
// Pure wiring, no latency; there is no backpressure because the bus is simply sampled.
interface icw_sequencer_if;
  logic       CS;
  logic       WR;
  logic       A0;
  logic [7:0] data_in;

  modport master (output CS, output WR, output A0, output data_in);
  modport slave  (input  CS, input  WR, input  A0, input  data_in);
endinterface

// File: rtl/icw_sequencer.sv
// Initialization/operation command-word sequencer: decodes ICW1-4 and OCW1-3 on the trailing edge of WR.
// Results appear one clock after the trailing edge, and strobes last one cycle. The bus is never stalled.
module icw_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  icw_sequencer_if.slave        bus,
  output logic [1:0]            icw_to_be_sent,
  output logic                  init_done,
  output logic [4:0]            vector_base,
  output logic                  sngl,
  output logic                  ic4,
  output logic                  ltim,
  output logic [7:0]            cascade_reg,
  output logic                  aeoi,
  output logic [7:0]            mask_reg,
  output logic                  eoi_pulse,
  output logic                  eoi_specific,
  output logic [2:0]            eoi_level,
  output logic                  read_isr,
  output logic                  poll_pulse
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic        cs_h_q, cs_h_d;
  logic        a0_h_q, a0_h_d;
  logic [7:0]  dat_h_q, dat_h_d;
  logic [4:0]  vector_base_q, vector_base_d;
  logic        sngl_q, sngl_d;
  logic        ic4_q, ic4_d;
  logic        ltim_q, ltim_d;
  logic [7:0]  cascade_q, cascade_d;
  logic        aeoi_q, aeoi_d;
  logic [7:0]  mask_q, mask_d;
  logic        eoi_pulse_q, eoi_pulse_d;
  logic        eoi_specific_q, eoi_specific_d;
  logic [2:0]  eoi_level_q, eoi_level_d;
  logic        read_isr_q, read_isr_d;
  logic        poll_pulse_q, poll_pulse_d;
  logic        wr_event;
  logic        is_icw1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_q           <= 1'b0;
      cs_h_q         <= 1'b0;
      a0_h_q         <= 1'b0;
      dat_h_q        <= 8'h00;
      vector_base_q  <= 5'h00;
      sngl_q         <= 1'b0;
      ic4_q          <= 1'b0;
      ltim_q         <= 1'b0;
      cascade_q      <= 8'h00;
      aeoi_q         <= 1'b0;
      mask_q         <= 8'h00;
      eoi_pulse_q    <= 1'b0;
      eoi_specific_q <= 1'b0;
      eoi_level_q    <= 3'h0;
      read_isr_q     <= 1'b0;
      poll_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      cs_h_q         <= cs_h_d;
      a0_h_q         <= a0_h_d;
      dat_h_q        <= dat_h_d;
      vector_base_q  <= vector_base_d;
      sngl_q         <= sngl_d;
      ic4_q          <= ic4_d;
      ltim_q         <= ltim_d;
      cascade_q      <= cascade_d;
      aeoi_q         <= aeoi_d;
      mask_q         <= mask_d;
      eoi_pulse_q    <= eoi_pulse_d;
      eoi_specific_q <= eoi_specific_d;
      eoi_level_q    <= eoi_level_d;
      read_isr_q     <= read_isr_d;
      poll_pulse_q   <= poll_pulse_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_d           = bus.WR;
    cs_h_d         = cs_h_q;
    a0_h_d         = a0_h_q;
    dat_h_d        = dat_h_q;
    vector_base_d  = vector_base_q;
    sngl_d         = sngl_q;
    ic4_d          = ic4_q;
    ltim_d         = ltim_q;
    cascade_d      = cascade_q;
    aeoi_d         = aeoi_q;
    mask_d         = mask_q;
    eoi_pulse_d    = 1'b0;
    eoi_specific_d = eoi_specific_q;
    eoi_level_d    = eoi_level_q;
    read_isr_d     = read_isr_q;
    poll_pulse_d   = 1'b0;

    // Holding registers track the bus while WR is low, so the last low cycle wins.
    if (!bus.WR) begin
      cs_h_d  = bus.CS;
      a0_h_d  = bus.A0;
      dat_h_d = bus.data_in;
    end

    wr_event = bus.WR && !wr_q && !cs_h_q;
    is_icw1  = !a0_h_q && dat_h_q[4];

    if (wr_event) begin
      if (is_icw1) begin
        ltim_d     = dat_h_q[3];
        sngl_d     = dat_h_q[1];
        ic4_d      = dat_h_q[0];
        mask_d     = 8'h00;
        aeoi_d     = 1'b0;
        cascade_d  = 8'h00;
        read_isr_d = 1'b0;
        state_d    = WAIT_ICW2;
      end else begin
        unique case (state_q)
          WAIT_ICW2: begin
            if (a0_h_q) begin
              vector_base_d = dat_h_q[7:3];
              if (!sngl_q)    state_d = WAIT_ICW3;
              else if (ic4_q) state_d = WAIT_ICW4;
              else            state_d = READY;
            end
          end
          WAIT_ICW3: begin
            if (a0_h_q) begin
              cascade_d = dat_h_q;
              state_d   = ic4_q ? WAIT_ICW4 : READY;
            end
          end
          WAIT_ICW4: begin
            if (a0_h_q) begin
              aeoi_d  = dat_h_q[1];
              state_d = READY;
            end
          end
          READY: begin
            if (a0_h_q) begin
              mask_d = dat_h_q;
            end else if (dat_h_q[4:3] == 2'b00) begin
              // OCW2 without the EOI bit carries rotate/priority commands not handled here.
              if (dat_h_q[5]) begin
                eoi_pulse_d    = 1'b1;
                eoi_specific_d = dat_h_q[6];
                eoi_level_d    = dat_h_q[2:0];
              end
            end else if (dat_h_q[4:3] == 2'b01) begin
              if (dat_h_q[1]) read_isr_d = dat_h_q[0];
              poll_pulse_d = dat_h_q[2];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    icw_to_be_sent = 2'b00;
    init_done      = 1'b0;
    unique case (state_q)
      WAIT_ICW2: icw_to_be_sent = 2'b01;
      WAIT_ICW3: icw_to_be_sent = 2'b10;
      WAIT_ICW4: icw_to_be_sent = 2'b11;
      READY:     init_done      = 1'b1;
      default:   ;
    endcase
  end

  assign vector_base  = vector_base_q;
  assign sngl         = sngl_q;
  assign ic4          = ic4_q;
  assign ltim         = ltim_q;
  assign cascade_reg  = cascade_q;
  assign aeoi         = aeoi_q;
  assign mask_reg     = mask_q;
  assign eoi_pulse    = eoi_pulse_q;
  assign eoi_specific = eoi_specific_q;
  assign eoi_level    = eoi_level_q;
  assign read_isr     = read_isr_q;
  assign poll_pulse   = poll_pulse_q;

endmodule

// File: tb/tb_icw_sequencer.sv
// Bench for icw_sequencer: directed command-word scenarios, then random writes and resets
// compared against a register-level model of the command-word rules.
module tb_icw_sequencer;
  logic clk = 1'b0;
  logic reset;

  icw_sequencer_if bus ();

  logic [1:0] icw_to_be_sent;
  logic       init_done;
  logic [4:0] vector_base;
  logic       sngl, ic4, ltim, aeoi, eoi_pulse, eoi_specific, read_isr, poll_pulse;
  logic [7:0] cascade_reg, mask_reg;
  logic [2:0] eoi_level;

  icw_sequencer dut (
    .clk(clk), .reset(reset), .bus(bus),
    .icw_to_be_sent(icw_to_be_sent), .init_done(init_done), .vector_base(vector_base),
    .sngl(sngl), .ic4(ic4), .ltim(ltim), .cascade_reg(cascade_reg), .aeoi(aeoi),
    .mask_reg(mask_reg), .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .read_isr(read_isr), .poll_pulse(poll_pulse)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model: phase 0 = nothing received, 1..3 = waiting for ICW2..ICW4, 4 = operational.
  int         m_phase;
  logic       m_sngl, m_ic4, m_ltim, m_aeoi, m_ris, m_es, m_eoi_p, m_poll_p;
  logic [4:0] m_vb;
  logic [7:0] m_casc, m_mask;
  logic [2:0] m_lvl;

  function automatic void model_reset();
    m_phase = 0; m_sngl = 0; m_ic4 = 0; m_ltim = 0; m_aeoi = 0; m_ris = 0; m_es = 0;
    m_eoi_p = 0; m_poll_p = 0; m_vb = 0; m_casc = 0; m_mask = 0; m_lvl = 0;
  endfunction

  function automatic void model_write(logic cs, logic a0, logic [7:0] d);
    m_eoi_p = 0;
    m_poll_p = 0;
    if (cs) return;
    if (!a0 && d[4]) begin
      m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_mask = 0; m_aeoi = 0; m_casc = 0; m_ris = 0;
      m_phase = 1;
      return;
    end
    if (!a0 && m_phase != 4) return;
    case (m_phase)
      1: begin m_vb = d[7:3]; m_phase = (m_sngl == 0) ? 2 : (m_ic4 ? 3 : 4); end
      2: begin m_casc = d; m_phase = m_ic4 ? 3 : 4; end
      3: begin m_aeoi = d[1]; m_phase = 4; end
      4: begin
        if (a0) m_mask = d;
        else if (d[4:3] == 2'b00 && d[5]) begin m_eoi_p = 1; m_es = d[6]; m_lvl = d[2:0]; end
        else if (d[4:3] == 2'b01) begin
          if (d[1]) m_ris = d[0];
          m_poll_p = d[2];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ctx);
    logic [1:0] e_icw;
    e_icw = (m_phase == 4) ? 2'b00 : 2'(m_phase);
    chk({ctx, "/icw"},   8'(icw_to_be_sent), 8'(e_icw));
    chk({ctx, "/done"},  8'(init_done),      8'(m_phase == 4));
    chk({ctx, "/vb"},    8'(vector_base),    8'(m_vb));
    chk({ctx, "/sngl"},  8'(sngl),           8'(m_sngl));
    chk({ctx, "/ic4"},   8'(ic4),            8'(m_ic4));
    chk({ctx, "/ltim"},  8'(ltim),           8'(m_ltim));
    chk({ctx, "/casc"},  cascade_reg,        m_casc);
    chk({ctx, "/aeoi"},  8'(aeoi),           8'(m_aeoi));
    chk({ctx, "/mask"},  mask_reg,           m_mask);
    chk({ctx, "/eoip"},  8'(eoi_pulse),      8'(m_eoi_p));
    chk({ctx, "/es"},    8'(eoi_specific),   8'(m_es));
    chk({ctx, "/lvl"},   8'(eoi_level),      8'(m_lvl));
    chk({ctx, "/ris"},   8'(read_isr),       8'(m_ris));
    chk({ctx, "/pollp"}, 8'(poll_pulse),     8'(m_poll_p));
  endtask

  // Holds WR low for 'hold' cycles (only the last cycle carries the real values),
  // releases it, checks the cycle after the event and that strobes drop the cycle after.
  task automatic do_write(string ctx, logic cs, logic a0, logic [7:0] d, int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.WR = 1'b0;
      if (i == hold - 1) begin
        bus.CS = cs; bus.A0 = a0; bus.data_in = d;
      end else begin
        bus.CS = cs; bus.A0 = 1'($urandom); bus.data_in = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.WR = 1'b1;
    bus.CS = 1'($urandom);
    bus.A0 = 1'($urandom);
    bus.data_in = 8'($urandom);
    @(negedge clk);
    model_write(cs, a0, d);
    check_all(ctx);
    @(negedge clk);
    chk({ctx, "/eoip_drop"},  8'(eoi_pulse),  8'h00);
    chk({ctx, "/pollp_drop"}, 8'(poll_pulse), 8'h00);
    m_eoi_p = 0;
    m_poll_p = 0;
  endtask

  task automatic do_reset(string ctx);
    @(negedge clk);
    reset = 1'b1;
    bus.WR = 1'b1;
    @(negedge clk);
    model_reset();
    check_all({ctx, "_in"});
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all({ctx, "_out"});
  endtask

  initial begin
    logic       r_cs, r_a0;
    logic [7:0] r_d;
    reset = 1'b1;
    bus.CS = 1'b1; bus.WR = 1'b1; bus.A0 = 1'b0; bus.data_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("reset");

    // ICW1 single+IC4, ICW2, ICW4 with AEOI.
    do_write("icw1_13", 0, 0, 8'h13, 1);
    chk("icw1_13/icw_const", 8'(icw_to_be_sent), 8'h01);
    do_write("icw2_48", 0, 1, 8'h48, 1);
    chk("icw2_48/vb_const",  8'(vector_base),    8'h09);
    chk("icw2_48/icw_const", 8'(icw_to_be_sent), 8'h03);
    do_write("icw4_03", 0, 1, 8'h03, 2);
    chk("icw4_03/aeoi_const", 8'(aeoi),      8'h01);
    chk("icw4_03/done_const", 8'(init_done), 8'h01);

    // Cascade sequence through every ICW.
    do_write("icw1_11", 0, 0, 8'h11, 3);
    chk("icw1_11/icw_const", 8'(icw_to_be_sent), 8'h01);
    do_write("icw2_20", 0, 1, 8'h20, 1);
    chk("icw2_20/icw_const", 8'(icw_to_be_sent), 8'h02);
    do_write("icw3_04", 0, 1, 8'h04, 2);
    chk("icw3_04/icw_const", 8'(icw_to_be_sent), 8'h03);
    do_write("icw4_01", 0, 1, 8'h01, 1);
    chk("icw4_01/casc_const", cascade_reg, 8'h04);
    chk("icw4_01/aeoi_const", 8'(aeoi),      8'h00);
    chk("icw4_01/done_const", 8'(init_done), 8'h01);

    // Operational commands.
    do_write("ocw1_f0", 0, 1, 8'hF0, 1);
    chk("ocw1_f0/mask_const", mask_reg, 8'hF0);
    do_write("ocw2_63", 0, 0, 8'h63, 2);
    chk("ocw2_63/es_const",  8'(eoi_specific), 8'h01);
    chk("ocw2_63/lvl_const", 8'(eoi_level),    8'h03);
    do_write("ocw2_noeoi", 0, 0, 8'h47, 1);
    do_write("ocw3_0b", 0, 0, 8'h0B, 1);
    chk("ocw3_0b/ris_const", 8'(read_isr), 8'h01);
    do_write("ocw3_0c", 0, 0, 8'h0C, 1);
    chk("ocw3_0c/ris_const", 8'(read_isr), 8'h01);
    do_write("cs_high", 1, 1, 8'h0F, 2);
    chk("cs_high/mask_const", mask_reg, 8'hF0);

    // Re-init from READY, then reset mid-sequence.
    do_write("icw1_12", 0, 0, 8'h12, 1);
    chk("icw1_12/mask_const", mask_reg, 8'h00);
    chk("icw1_12/done_const", 8'(init_done), 8'h00);
    do_write("icw2_direct", 0, 1, 8'hA8, 1);
    chk("icw2_direct/done_const", 8'(init_done), 8'h01);
    do_write("icw1_again", 0, 0, 8'h1B, 1);
    do_reset("mid_reset");
    chk("mid_reset/icw_const", 8'(icw_to_be_sent), 8'h00);
    do_write("after_reset_icw2", 0, 1, 8'h48, 1);
    chk("after_reset_icw2/icw_const", 8'(icw_to_be_sent), 8'h00);

    // Reset coinciding with the write-release edge must win.
    @(negedge clk);
    bus.WR = 1'b0; bus.CS = 1'b0; bus.A0 = 1'b0; bus.data_in = 8'h13;
    @(negedge clk);
    bus.WR = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset_vs_write");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        do_reset("rnd_reset");
      end else begin
        r_cs = ($urandom_range(0, 9) == 0);
        r_a0 = 1'($urandom);
        r_d  = 8'($urandom);
        if (!r_a0 && m_phase != 0 && $urandom_range(0, 99) < 85) r_d[4] = 1'b0;
        do_write("rnd", r_cs, r_a0, r_d, $urandom_range(1, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
